// File: rtl/mm_pkg.sv
// mm_pkg: shared types and constants for the 2x2-MAC matrix-multiply sequencer.
// Provides the FSM state enum, default geometry, accumulator width,
// dot-product select codes and a row-major linear address helper.
package mm_pkg;

    localparam int N_DEF  = 8;
    localparam int AW_DEF = 8;
    localparam int ACC_W  = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACC,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    // acc_sel codes: bit 1 picks the A row of the tile, bit 0 the B column
    localparam logic [1:0] SEL_00 = 2'd0;
    localparam logic [1:0] SEL_01 = 2'd1;
    localparam logic [1:0] SEL_10 = 2'd2;
    localparam logic [1:0] SEL_11 = 2'd3;

    function automatic int lin_addr(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/mm_tile_counter.sv
// mm_tile_counter: nested tile-row / tile-col / k counters for the sequencer.
// Ports: clk, reset (async high); clr_i zeroes all counters; k_inc_i steps k
// (wrapping after N-1); tile_inc_i steps c then r in row-major tile order.
// Outputs r_o, c_o, k_o plus last_k_o / last_tile_o flags.
module mm_tile_counter
    import mm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int KW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          k_inc_i,
    input  logic          tile_inc_i,
    output logic [KW-1:0] r_o,
    output logic [KW-1:0] c_o,
    output logic [KW-1:0] k_o,
    output logic          last_k_o,
    output logic          last_tile_o
);

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] T_LAST = KW'(N / 2 - 1);

    logic [KW-1:0] r_q, r_d;
    logic [KW-1:0] c_q, c_d;
    logic [KW-1:0] k_q, k_d;

    assign r_o         = r_q;
    assign c_o         = c_q;
    assign k_o         = k_q;
    assign last_k_o    = (k_q == K_LAST);
    assign last_tile_o = (r_q == T_LAST) && (c_q == T_LAST);

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        k_d = k_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
            k_d = '0;
        end else begin
            if (k_inc_i) begin
                k_d = last_k_o ? '0 : k_q + KW'(1);
            end
            if (tile_inc_i) begin
                if (c_q == T_LAST) begin
                    c_d = '0;
                    r_d = last_tile_o ? '0 : r_q + KW'(1);
                end else begin
                    c_d = c_q + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
            c_q <= '0;
            k_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: walks 2x2 output tiles of C = A*B, driving RAM read
// addresses, MAC clear/enable and the serial drain into the output RAM.
// Ports: clk, reset (async high), start -> busy, done; addr_a1/a2, addr_b1/b2;
// mac_clear, mac_en, acc_sel, c_we, c_addr; cycle_count (busy cycles).
// Build option MM_SEQ_PERF_CNT_EN enables cycle_count; otherwise it reads 0.
module mm_tile_sequencer
    import mm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr_a1,
    output logic [AW-1:0] addr_a2,
    output logic [AW-1:0] addr_b1,
    output logic [AW-1:0] addr_b2,
    output logic          mac_clear,
    output logic          mac_en,
    output logic [1:0]    acc_sel,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [10:0]   cycle_count
);

    localparam int KW = $clog2(N);

    state_e        state_q;
    logic          busy_q, done_q, mac_clear_q, mac_en_q, c_we_q;
    logic [1:0]    acc_sel_q;
    logic [AW-1:0] c_addr_q;
    logic [AW-1:0] a1_q, a2_q, b1_q, b2_q;

    logic [KW-1:0] r, c, k;
    logic          last_k, last_tile;
    logic          accept, k_inc, tile_inc;

    assign accept   = (state_q == S_IDLE) && start;
    assign k_inc    = (state_q == S_ACC);
    assign tile_inc = (state_q == S_DRAIN) && (acc_sel_q == SEL_11);

    mm_tile_counter #(
        .N  (N),
        .KW (KW)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (accept),
        .k_inc_i     (k_inc),
        .tile_inc_i  (tile_inc),
        .r_o         (r),
        .c_o         (c),
        .k_o         (k),
        .last_k_o    (last_k),
        .last_tile_o (last_tile)
    );

    function automatic logic [AW-1:0] rd_addr(input logic [KW-1:0] blk,
                                              input logic          half,
                                              input logic [KW-1:0] kk);
        return AW'(lin_addr(2 * int'(blk) + int'(half), int'(kk), N));
    endfunction

    function automatic logic [AW-1:0] wr_addr(input logic [KW-1:0] rr,
                                              input logic [KW-1:0] cc,
                                              input logic [1:0]    sel);
        return AW'(lin_addr(2 * int'(rr) + int'(sel[1]),
                            2 * int'(cc) + int'(sel[0]), N));
    endfunction

    // Addresses are registered one cycle ahead so that during ACC cycle k
    // the RAMs see k; entering ACC from CLEAR always starts at k = 0.
    logic [KW-1:0] k_nxt;
    logic [1:0]    sel_nxt;
    assign k_nxt   = (state_q == S_CLEAR) ? '0 : k + KW'(1);
    assign sel_nxt = (state_q == S_FLUSH) ? SEL_00 : acc_sel_q + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            c_we_q      <= 1'b0;
            acc_sel_q   <= SEL_00;
            c_addr_q    <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
        end else begin
            // RAM read latency is one cycle, so MACs trail ACC by one
            mac_en_q    <= (state_q == S_ACC);
            done_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            c_we_q      <= 1'b0;
            acc_sel_q   <= SEL_00;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_CLEAR;
                        busy_q      <= 1'b1;
                        mac_clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_ACC;
                    a1_q    <= rd_addr(r, 1'b0, k_nxt);
                    a2_q    <= rd_addr(r, 1'b1, k_nxt);
                    b1_q    <= rd_addr(c, 1'b0, k_nxt);
                    b2_q    <= rd_addr(c, 1'b1, k_nxt);
                end
                S_ACC: begin
                    if (last_k) begin
                        state_q <= S_FLUSH;
                    end else begin
                        a1_q <= rd_addr(r, 1'b0, k_nxt);
                        a2_q <= rd_addr(r, 1'b1, k_nxt);
                        b1_q <= rd_addr(c, 1'b0, k_nxt);
                        b2_q <= rd_addr(c, 1'b1, k_nxt);
                    end
                end
                S_FLUSH: begin
                    state_q   <= S_DRAIN;
                    c_we_q    <= 1'b1;
                    acc_sel_q <= sel_nxt;
                    c_addr_q  <= wr_addr(r, c, sel_nxt);
                end
                S_DRAIN: begin
                    if (acc_sel_q == SEL_11) begin
                        if (last_tile) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_CLEAR;
                            mac_clear_q <= 1'b1;
                        end
                    end else begin
                        c_we_q    <= 1'b1;
                        acc_sel_q <= sel_nxt;
                        c_addr_q  <= wr_addr(r, c, sel_nxt);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_clear = mac_clear_q;
    assign mac_en    = mac_en_q;
    assign c_we      = c_we_q;
    assign acc_sel   = acc_sel_q;
    assign c_addr    = c_addr_q;
    assign addr_a1   = a1_q;
    assign addr_a2   = a2_q;
    assign addr_b1   = b1_q;
    assign addr_b2   = b2_q;

`ifdef MM_SEQ_PERF_CNT_EN
    logic [10:0] cnt_q;

    // Saturating busy-cycle count; cleared only by an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy_q && (cnt_q != 11'h7FF)) begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

    assign cycle_count = cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb_mm_tile_sequencer: drives mm_tile_sequencer with RAM/MAC datapath models
// and compares the written C matrix and control timing against A*B.
module tb_mm_tile_sequencer;

    localparam int N        = 8;
    localparam int AW       = 8;
    localparam int TILES    = (N / 2) * (N / 2);
    localparam int TILE_CYC = N + 6;
    localparam int BUSY_CYC = TILES * TILE_CYC;
    localparam int SENTINEL = 999999999;
`ifdef MM_SEQ_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, mac_clear, mac_en, c_we;
    logic [AW-1:0] addr_a1, addr_a2, addr_b1, addr_b2, c_addr;
    logic [1:0]    acc_sel;
    logic [10:0]   cycle_count;
    logic [57:0]   outs;

    mm_tile_sequencer #(.N(N), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .addr_a1     (addr_a1),
        .addr_a2     (addr_a2),
        .addr_b1     (addr_b1),
        .addr_b2     (addr_b2),
        .mac_clear   (mac_clear),
        .mac_en      (mac_en),
        .acc_sel     (acc_sel),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .cycle_count (cycle_count)
    );

    assign outs = {busy, done, addr_a1, addr_a2, addr_b1, addr_b2,
                   mac_clear, mac_en, acc_sel, c_we, c_addr, cycle_count};

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int amat [N][N];
    int bmat [N][N];
    int cref [N][N];
    logic signed [7:0] ram_a [256];
    logic signed [7:0] ram_b [256];
    int c_mem [256];
    int wr_cnt [256];
    int acc [4];
    int rd_a1, rd_a2, rd_b1, rd_b2;

    int cyc;
    int busy_cnt, en_cnt, we_cnt, both_cnt, done_cnt, done_cyc;
    int tile_en, tile_we, tile_open;
    int cc_done, cc_after, busy226, clr227;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: A identity, B[k][j]=k*8+j; mode 1: all -128; mode 2: random
    task automatic load(input int mode);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (mode)
                    0: begin
                        amat[i][j] = (i == j) ? 1 : 0;
                        bmat[i][j] = i * N + j;
                    end
                    1: begin
                        amat[i][j] = -128;
                        bmat[i][j] = -128;
                    end
                    default: begin
                        amat[i][j] = int'($urandom_range(255)) - 128;
                        bmat[i][j] = int'($urandom_range(255)) - 128;
                    end
                endcase
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ram_a[i * N + j] = 8'(amat[i][j]);
                ram_b[j * N + i] = 8'(bmat[i][j]);
                cref[i][j] = 0;
                for (int kk = 0; kk < N; kk++) begin
                    cref[i][j] += amat[i][kk] * bmat[kk][j];
                end
            end
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < 256; a++) begin
            c_mem[a]  = SENTINEL;
            wr_cnt[a] = 0;
        end
        acc = '{0, 0, 0, 0};
        rd_a1 = 0; rd_a2 = 0; rd_b1 = 0; rd_b2 = 0;
        busy_cnt = 0; en_cnt = 0; we_cnt = 0; both_cnt = 0;
        done_cnt = 0; done_cyc = -1;
        tile_en = 0; tile_we = 0; tile_open = 0;
        cc_done = -1; cc_after = -1; busy226 = -1; clr227 = -1;
    endtask

    // One clock: sample at the falling edge, then apply the datapath
    // effects of the rising edge that closes this cycle.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (busy && cyc <= BUSY_CYC + 2) busy_cnt++;
        if (mac_en) begin en_cnt++; tile_en++; end
        if (c_we) begin we_cnt++; tile_we++; end
        if (mac_en && mac_clear) both_cnt++;
        if (cyc == 1) chk("clear_at_c1", mac_clear, 1);
        if (mac_clear) begin
            if (tile_open != 0) begin
                chk("tile_mac_en", tile_en, N);
                chk("tile_c_we", tile_we, 4);
            end
            tile_open = 1; tile_en = 0; tile_we = 0;
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (tile_open != 0) begin
                chk("tile_mac_en", tile_en, N);
                chk("tile_c_we", tile_we, 4);
            end
            tile_open = 0;
        end
        if (cyc == BUSY_CYC + 1) cc_done = int'(cycle_count);
        if (cyc == BUSY_CYC + 2) begin
            cc_after = int'(cycle_count);
            busy226 = int'(busy);
        end
        if (cyc == BUSY_CYC + 3) clr227 = int'(mac_clear);
        if (c_we) begin
            c_mem[c_addr] = acc[acc_sel];
            wr_cnt[c_addr]++;
        end
        if (mac_clear) begin
            acc = '{0, 0, 0, 0};
        end else if (mac_en) begin
            acc[0] += rd_a1 * rd_b1;
            acc[1] += rd_a1 * rd_b2;
            acc[2] += rd_a2 * rd_b1;
            acc[3] += rd_a2 * rd_b2;
        end
        rd_a1 = int'(ram_a[addr_a1]);
        rd_a2 = int'(ram_a[addr_a2]);
        rd_b1 = int'(ram_b[addr_b1]);
        rd_b2 = int'(ram_b[addr_b2]);
    endtask

    task automatic run_mm(input int pulse_at, input int abort_at, input bit hold);
        clear_model();
        cyc = 0;
        start = 1'b1;
        for (int i = 0; i < BUSY_CYC + 10; i++) begin
            step();
            if (cyc == 1 && !hold) start = 1'b0;
            if (cyc == pulse_at) start = 1'b1;
            if (cyc == pulse_at + 1 && !hold) start = 1'b0;
            if (cyc == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_outs_zero", outs, 0);
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            if (cyc >= BUSY_CYC + 3) break;
        end
    endtask

    task automatic check_run(input string tag);
        int bad;
        chk({tag, "_done_cycle"}, done_cyc, BUSY_CYC + 1);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, BUSY_CYC);
        chk({tag, "_mac_en_total"}, en_cnt, TILES * N);
        chk({tag, "_c_we_total"}, we_cnt, TILES * 4);
        chk({tag, "_clear_en_overlap"}, both_cnt, 0);
        chk({tag, "_cc_at_done"}, cc_done, PERF != 0 ? BUSY_CYC : 0);
        chk({tag, "_cc_hold"}, cc_after, PERF != 0 ? BUSY_CYC : 0);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (wr_cnt[a] != ((a < N * N) ? 1 : 0)) bad++;
        end
        chk({tag, "_c_addr_once"}, bad, 0);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                chk($sformatf("%s_c%0d_%0d", tag, i, j), c_mem[i * N + j], cref[i][j]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs_zero", outs, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_not_busy", busy, 0);

        load(0);
        run_mm(-1, -1, 1'b0);
        check_run("ident");
        chk("ident_c19", c_mem[19], 19);

        load(1);
        run_mm(-1, -1, 1'b0);
        check_run("m128");
        chk("m128_c37", c_mem[37], 131072);

        load(2);
        run_mm(45, -1, 1'b0);
        check_run("rand_pulse");

        load(2);
        run_mm(-1, 50, 1'b0);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", busy, 0);

        load(2);
        run_mm(-1, -1, 1'b0);
        check_run("after_abort");

        load(2);
        run_mm(-1, -1, 1'b1);
        check_run("hold");
        chk("hold_idle_226", busy226, 0);
        chk("hold_restart_227", clr227, 1);
        reset = 1'b1;
        #1;
        chk("final_reset_zero", outs, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_tile_sequencer.md
# mm_tile_sequencer

Sequencer for the 2x2-MAC matrix-multiply datapath: computes C = A·B for N×N signed 8-bit matrices by walking 2×2 output tiles. For each tile it generates the four dual-port RAM read addresses, clears and gates the four MACs, then drains the four dot products serially into the output RAM. It sits between the top-level start/done interface and the RAMA/RAMB/RAMOUTPUT/MAC datapath, replacing ad-hoc address registers and the output buffer counter.

## Interface
Parameters:
- N, 8, matrix dimension; must be even, N*N <= 2**AW
- AW, 8, RAM address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a multiply; sampled only in IDLE
- busy  out  1  high from the first CLEAR through the last DRAIN cycle
- done  out  1  one-cycle pulse after the final C write
- addr_a1, addr_a2  out  AW  RAMA port 1/2 read addresses
- addr_b1, addr_b2  out  AW  RAMB port 1/2 read addresses
- mac_clear  out  1  zero all four MAC accumulators
- mac_en  out  1  MACs accumulate this cycle
- acc_sel  out  2  selects dot product 0..3 onto output RAM data
- c_we  out  1  output RAM write enable
- c_addr  out  AW  output RAM write address
- cycle_count  out  11  busy-cycle counter (see Configuration)

## Operation
- Storage: A row-major (A[i][k] at i*N+k); B column-major (B[k][j] at j*N+k); C row-major (C[i][j] at i*N+j).
- Counters: tile row r, tile col c in 0..N/2-1 (c inner, row-major tile order); k in 0..N-1.
- Addresses: addr_a1=2r*N+k, addr_a2=(2r+1)*N+k, addr_b1=2c*N+k, addr_b2=(2c+1)*N+k; driven from registered counters, held outside ACC.
- FSM states: IDLE, CLEAR, ACC, FLUSH, DRAIN, DONE.
  - IDLE: start=1 -> CLEAR; r=c=k=0; cycle_count cleared.
  - CLEAR (1 cycle): mac_clear=1.
  - ACC (N cycles): addresses present k; k increments; k==N-1 -> FLUSH.
  - FLUSH (1 cycle): last RAM data accumulates.
  - DRAIN (4 cycles): c_we=1, acc_sel=0..3 -> c_addr = 2r*N+2c, 2r*N+2c+1, (2r+1)*N+2c, (2r+1)*N+2c+1; then next tile -> CLEAR, or after last tile -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- mac_en is (state==ACC) registered one cycle (RAM read latency 1): high during ACC cycles 1..N-1 and FLUSH, exactly N cycles per tile.
- mac_clear and mac_en never both high; during DRAIN both low so MAC outputs hold.
- start while busy or in DONE: ignored. start held high in IDLE: restarts immediately.

## Timing
- Reset values: state IDLE, all outputs 0 (addresses, acc_sel, c_addr, cycle_count included).
- reset mid-operation: immediate return to IDLE, partial C contents undefined, no done pulse.
- start sampled at edge 0 -> CLEAR in cycle 1; per tile N+6 cycles (1+N+1+4).
- N=8: tile 0 CLEAR cycle 1, ACC 2–9, FLUSH 10, DRAIN 11–14; last DRAIN cycle 224; done cycle 225.
- Total busy cycles = (N/2)² · (N+6).
- cycle_count increments each busy cycle, saturates at 2047, holds after done until next accepted start.

## Configuration
- MM_SEQ_PERF_CNT_EN defined: cycle_count implemented as above.
- Not defined: counter logic removed, cycle_count tied to 0; all other behaviour identical.

## Structure
- Shared package mm_pkg: state enum (IDLE..DONE), default N/AW, ACC_W=19, acc_sel encoding constants.
- One sub-module: mm_tile_counter (nested r/c/k counters with last_k/last_tile flags); FSM and address/write decode in top.

## Test plan
- N=8, A=identity, B[k][j]=k*8+j (column-major load) -> C equals B row-major; done at cycle 225; cycle_count=224.
- N=8, all A=B=-128 -> every C entry = 131072 (fits 19-bit signed width check at MAC), 64 writes, each c_addr 0..63 exactly once.
- Check mac_en high exactly 8 cycles per tile, never with mac_clear; c_we high exactly 4 cycles per tile, 64 total.
- Pulse start during ACC of tile 3 -> ignored; done still single pulse at cycle 225.
- Assert reset at cycle 50 -> all outputs 0 next sample, state IDLE; new start -> full correct run.
- Build without MM_SEQ_PERF_CNT_EN -> cycle_count stays 0, C results and done timing unchanged.
